// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between a buffered capture-side write port and a
// single-cycle VGA read port, with a bounded read streak while writes wait.
module sram_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic        ZX_14M,
   input  logic        RST,
   input  logic        WR_VALID,
   input  logic [18:0] WR_ADDR,
   input  logic [7:0]  WR_DATA,
   output logic        WR_READY,
   input  logic        RD_VALID,
   input  logic [18:0] RD_ADDR,
   output logic        RD_READY,
   output logic [7:0]  RD_DATA,
   output logic        RD_DATA_VALID,
   output logic [18:0] SRAM_Addr,
   inout  wire  [7:0]  SRAM_D,
   output logic        SRAM_OE,
   output logic        SRAM_WE,
   output logic        SRAM_CS,
   output logic [4:0]  FIFO_LEVEL,
   output logic        OVERRUN
);

   localparam int PW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [4:0]    DEPTH_L  = 5'(FIFO_DEPTH);
   localparam logic [SW-1:0] STARVE_L = SW'(STARVE_MAX);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD        = 3'd1,
      TURN      = 3'd2,
      WR_SETUP  = 3'd3,
      WR_STROBE = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [18:0]   r_fifo_addr [FIFO_DEPTH];
   logic [7:0]    r_fifo_data [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [4:0]    r_level;
   logic [4:0]    w_level_next;
   logic [SW-1:0] r_starve;
   logic [SW-1:0] w_starve_next;
   logic          r_overrun;
   logic [18:0]   r_addr;
   logic [7:0]    r_wdata;
   logic          r_d_oe;
   logic          r_cs;
   logic          r_oe;
   logic          r_we;
   logic [7:0]    r_rd_data;
   logic          r_rd_valid;

   logic w_decide;
   logic w_empty;
   logic w_full;
   logic w_force;
   logic w_rd_grant;
   logic w_wr_grant;
   logic w_push;
   logic w_pop;

   assign w_decide   = (r_state == IDLE) || (r_state == RD) || (r_state == WR_STROBE);
   assign w_empty    = (r_level == 5'd0);
   assign w_full     = (r_level == DEPTH_L);
   assign w_force    = (r_starve == STARVE_L) && !w_empty;
   assign w_rd_grant = w_decide && RD_VALID && !w_force;
   assign w_wr_grant = w_decide && !w_empty && (w_force || !RD_VALID);
   assign w_push     = WR_VALID && !w_full;
   // A grant from RD detours through TURN, so its pop happens one edge later.
   assign w_pop      = (r_state == TURN) || (w_wr_grant && (r_state != RD));

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         TURN:     w_next_state = WR_SETUP;
         WR_SETUP: w_next_state = WR_STROBE;
         default: begin
            if (w_wr_grant)
               w_next_state = (r_state == RD) ? TURN : WR_SETUP;
            else if (w_rd_grant)
               w_next_state = RD;
            else
               w_next_state = IDLE;
         end
      endcase
   end

   always_comb begin
      w_level_next = r_level;
      if (w_push && !w_pop)
         w_level_next = r_level + 5'd1;
      else if (!w_push && w_pop)
         w_level_next = r_level - 5'd1;
   end

   always_comb begin
      w_starve_next = r_starve;
      if (w_wr_grant || (w_level_next == 5'd0))
         w_starve_next = '0;
      else if (w_rd_grant && !w_empty && (r_starve != STARVE_L))
         w_starve_next = r_starve + SW'(1);
   end

   always_ff @(posedge ZX_14M) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= WR_ADDR;
         r_fifo_data[r_wr_ptr] <= WR_DATA;
      end
   end

   always_ff @(posedge ZX_14M or posedge RST) begin
      if (RST) begin
         r_state    <= IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_starve   <= '0;
         r_overrun  <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_d_oe     <= 1'b0;
         r_cs       <= 1'b1;
         r_oe       <= 1'b1;
         r_we       <= 1'b1;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_level  <= w_level_next;
         r_starve <= w_starve_next;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_addr   <= r_fifo_addr[r_rd_ptr];
            r_wdata  <= r_fifo_data[r_rd_ptr];
         end else if (w_rd_grant) begin
            r_addr <= RD_ADDR;
         end
         if (WR_VALID && w_full)
            r_overrun <= 1'b1;
         // Strobes are decoded from the next state so they line up with the new phase.
         r_cs   <= !((w_next_state == RD) || (w_next_state == WR_SETUP) || (w_next_state == WR_STROBE));
         r_oe   <= !(w_next_state == RD);
         r_we   <= !(w_next_state == WR_STROBE);
         r_d_oe <= (w_next_state == WR_SETUP) || (w_next_state == WR_STROBE);
         r_rd_valid <= (r_state == RD);
         if (r_state == RD)
            r_rd_data <= SRAM_D;
      end
   end

   assign SRAM_D        = r_d_oe ? r_wdata : 8'bz;
   assign SRAM_Addr     = r_addr;
   assign SRAM_CS       = r_cs;
   assign SRAM_OE       = r_oe;
   assign SRAM_WE       = r_we;
   assign WR_READY      = !w_full;
   assign RD_READY      = w_rd_grant;
   assign RD_DATA       = r_rd_data;
   assign RD_DATA_VALID = r_rd_valid;
   assign FIFO_LEVEL    = r_level;
   assign OVERRUN       = r_overrun;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, gives the write-buffer depth in entries; it SHALL be a power of two, 2..16.
REQ-002 Parameter STARVE_MAX, default 3, gives the number of consecutive read grants allowed while writes are pending.
REQ-003 ZX_14M  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 WR_VALID  in  1  capture side has a write pending.
REQ-006 WR_ADDR  in  19  write address; WR_DATA  in  8  write data (two packed RGBI pixels).
REQ-007 WR_READY  out  1  write FIFO can accept; equals "FIFO not full".
REQ-008 RD_VALID  in  1  VGA side requests a read; RD_ADDR  in  19  read address.
REQ-009 RD_READY  out  1  read accepted this cycle (combinational from state, FIFO level and starve count).
REQ-010 RD_DATA  out  8  read data; RD_DATA_VALID  out  1  one-cycle strobe qualifying RD_DATA.
REQ-011 SRAM_Addr  out  19;  SRAM_D  inout  8;  SRAM_OE, SRAM_WE, SRAM_CS  out  1, all active-low and registered.
REQ-012 FIFO_LEVEL  out  5  current FIFO occupancy; OVERRUN  out  1  sticky flag, set on WR_VALID while full.

Function
REQ-013 The FSM SHALL have the states IDLE, RD, TURN, WR_SETUP and WR_STROBE.
REQ-014 A decision point SHALL occur in each cycle whose state is IDLE, RD or WR_STROBE; TURN SHALL always go to WR_SETUP, and WR_SETUP SHALL always go to WR_STROBE.
REQ-015 Decision priority SHALL be: (a) forced write if starve==STARVE_MAX and FIFO non-empty; (b) read if RD_VALID; (c) write if FIFO non-empty; (d) IDLE.
REQ-016 A write chosen from RD SHALL pass through TURN, with CS, OE and WE high and SRAM_D at Z; a write chosen from IDLE or WR_STROBE SHALL go directly to WR_SETUP.
REQ-017 RD_READY SHALL be 1 exactly when in a decision cycle, RD_VALID is 1 and rule (a) does not apply.
REQ-018 Read: at the accepting edge E0, register SRAM_Addr=RD_ADDR and drive CS=0, OE=0, WE=1 for the following cycle.
REQ-019 At edge E1, RD_DATA SHALL take SRAM_D, and RD_DATA_VALID SHALL be 1 for the cycle after E1; the read latency is therefore 2 edges.
REQ-020 Back-to-back reads SHALL sustain one read per clock.
REQ-021 Write: the FIFO pops at the edge entering WR_SETUP, and SRAM_Addr/SRAM_D take the head entry.
REQ-022 In WR_SETUP, CS=0, OE=1 and WE=1; in WR_STROBE, CS=0, OE=1 and WE=0 with address and data held.
REQ-023 SRAM_D SHALL be driven only in WR_SETUP and WR_STROBE, and SHALL be Z otherwise.
REQ-024 In IDLE, CS, OE and WE SHALL all be 1.
REQ-025 The starve counter SHALL increment on each read grant while the FIFO is non-empty, saturate at STARVE_MAX, and clear on a write grant or when the FIFO is empty.
REQ-026 The FIFO SHALL push on WR_VALID&WR_READY and pop on the write grant; a simultaneous push and pop SHALL leave the level unchanged.
REQ-027 Writes SHALL leave the FIFO in FIFO order, with pointer wrap modulo FIFO_DEPTH.
REQ-028 When the FIFO is full, WR_READY SHALL be 0 even if a pop occurs the same cycle, so a push is never accepted while full.
REQ-029 When the FIFO is empty, no write grant SHALL occur and the starve counter SHALL read 0.
REQ-030 OVERRUN SHALL be set at any edge with WR_VALID=1 and the FIFO full, and SHALL clear only on reset.

Reset
REQ-031 While RST=1, the block SHALL force state IDLE, SRAM_CS=SRAM_OE=SRAM_WE=1, SRAM_D=Z and SRAM_Addr=0.
REQ-032 While RST=1, RD_DATA=0, RD_DATA_VALID=0, FIFO_LEVEL=0, FIFO pointers=0, starve=0 and OVERRUN=0.
REQ-033 RST asserted mid-write SHALL drive WE high immediately (asynchronously) and discard the in-flight entry and all FIFO contents.
REQ-034 After RST deasserts, the first decision SHALL occur at the first clock edge.

Verification
REQ-035 Reset, then RD_VALID=1 with RD_ADDR=0x00010 and the SRAM model holding 0xA5 -> RD_READY=1 at once; OE low the next cycle; RD_DATA=0xA5 with RD_DATA_VALID=1 two edges after acceptance.
REQ-036 One write (0x12345, 0x3C) from IDLE with no reads -> WR_SETUP then WR_STROBE; WE low for exactly 1 cycle; SRAM word 0x12345=0x3C; FIFO_LEVEL returns to 0.
REQ-037 RD_VALID held high continuously with 1 write queued -> exactly 3 reads, then RD_READY=0, then TURN, WR_SETUP and WR_STROBE, then reads resume.
REQ-038 Push 5 writes on consecutive cycles while reads saturate (FIFO_DEPTH=4) -> WR_READY=0 at level 4 and OVERRUN=1; entries written in push order; the 5th is never written.
REQ-039 Assert RST during WR_STROBE -> WE=1 within the same cycle, SRAM_D=Z, FIFO_LEVEL=0, and no corrupt write once RST is released.
REQ-040 A bus monitor on every cycle SHALL confirm that SRAM_D is never driven while OE=0 and that at least one TURN cycle separates OE=0 from SRAM_D driven.
